// File: rtl/display_pkg.sv
// display_pkg: shared widths, FSM state type and BCD digit-adjust helper for the display source arbiter.
package display_pkg;
  localparam int DISP_DIGITS = 5;
  localparam int BIN_W = 16;
  localparam int BCD_W = 20;
  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_DWELL} disp_arb_state_t;
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < DISP_DIGITS; i++)
      r[4*i+:4] = (b[4*i+:4] >= 4'd5) ? b[4*i+:4] + 4'd3 : b[4*i+:4];
    return r;
  endfunction
endpackage

// File: rtl/display_source_arbiter_if.sv
// display_source_arbiter_if: requester-side handshake and display-side result bundle.
interface display_source_arbiter_if #(parameter int N_REQ = 4);
  import display_pkg::*;
  logic [N_REQ-1:0] req;
  logic [BIN_W*N_REQ-1:0] value;
  logic [N_REQ-1:0] ack;
  logic [2:0] owner;
  logic [BCD_W-1:0] bcd_out;
  logic bcd_valid;
  logic busy;
  logic [DISP_DIGITS-1:0] blank_n;
  modport master (output req, value, input ack, owner, bcd_out, bcd_valid, busy, blank_n);
  modport slave (input req, value, output ack, owner, bcd_out, bcd_valid, busy, blank_n);
endinterface

// File: rtl/display_source_arbiter_bin2bcd_seq.sv
// bin2bcd_seq: 16-cycle shift-add-3 converter; start loads the operand, done flags the final iteration
// with dout already holding the finished result that cycle.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] din,
  output logic             done,
  output logic [BCD_W-1:0] dout
);
  logic [BIN_W-1:0] bin_q, bin_d, bin_sh;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_sh;
  logic [3:0] cnt_q, cnt_d;
  logic run_q, run_d;
  always_comb begin
    {bcd_sh, bin_sh} = {bcd_adjust(bcd_q), bin_q} << 1;
    done = run_q && cnt_q == 4'd15;
    dout = bcd_sh;
    bin_d = start ? din : run_q ? bin_sh : bin_q;
    bcd_d = start ? '0 : run_q ? bcd_sh : bcd_q;
    cnt_d = start ? '0 : run_q ? cnt_q + 4'd1 : cnt_q;
    run_d = start | (run_q & ~done);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
endmodule

// File: rtl/display_source_arbiter.sv
// display_source_arbiter: round-robin owner of the 5-digit display, BCD conversion and dwell hold.
// Optional leading-zero blanking via DISP_LEADING_ZERO_BLANK_EN.
module display_source_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input logic clk,
  input logic rst,
  display_source_arbiter_if.slave bus
);
  localparam int DW = (DWELL_CYCLES < 1) ? 1 : DWELL_CYCLES;
  localparam int CW = $clog2(DW + 1);
  disp_arb_state_t state_q, state_d;
  logic [2:0] rr_q, rr_d, owner_q, owner_d, pick;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, conv_out;
  logic valid_q, valid_d, busy_q, busy_d, hit, grant, load, conv_done;
  logic [CW-1:0] dwell_q, dwell_d;
  bin2bcd_seq u_conv (
    .clk(clk), .rst(rst), .start(grant),
    .din(bus.value[BIN_W*int'(pick)+:BIN_W]),
    .done(conv_done), .dout(conv_out)
  );
  // first requester at or after rr_q, wrapping
  always_comb begin
    hit = 1'b0;
    pick = '0;
    for (int k = 0; k < N_REQ; k++)
      if (!hit && bus.req[(int'(rr_q) + k) % N_REQ]) begin
        hit = 1'b1;
        pick = 3'((int'(rr_q) + k) % N_REQ);
      end
  end
  always_comb begin
    grant = state_q == ST_IDLE && hit;
    load = state_q == ST_CONVERT && conv_done;
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    state_d = grant ? ST_CONVERT : ST_IDLE;
      ST_CONVERT: state_d = load ? ST_DWELL : ST_CONVERT;
      ST_DWELL:   state_d = dwell_q == CW'(1) ? ST_IDLE : ST_DWELL;
      default:    state_d = ST_IDLE;
    endcase
    ack_d = grant ? {{(N_REQ-1){1'b0}}, 1'b1} << pick : '0;
    owner_d = grant ? pick : owner_q;
    rr_d = grant ? 3'((int'(pick) + 1) % N_REQ) : rr_q;
    bcd_d = load ? conv_out : bcd_q;
    valid_d = load | valid_q;
    dwell_d = load ? CW'(DW) : state_q == ST_DWELL ? dwell_q - CW'(1) : dwell_q;
    busy_d = state_d != ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q <= '0;
      owner_q <= '0;
      ack_q <= '0;
      bcd_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      owner_q <= owner_d;
      ack_q <= ack_d;
      bcd_q <= bcd_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      dwell_q <= dwell_d;
    end
  assign bus.ack = ack_q;
  assign bus.owner = owner_q;
  assign bus.bcd_out = bcd_q;
  assign bus.bcd_valid = valid_q;
  assign bus.busy = busy_q;
`ifdef DISP_LEADING_ZERO_BLANK_EN
  logic [DISP_DIGITS-1:0] blank_q, blank_d, lit;
  // a digit is lit when it or any more significant digit is nonzero; units always lit
  always_comb begin
    lit = '0;
    for (int i = 0; i < DISP_DIGITS; i++)
      for (int j = i; j < DISP_DIGITS; j++)
        lit[i] = lit[i] | (|conv_out[4*j+:4]);
    lit[0] = 1'b1;
    blank_d = load ? lit : blank_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) blank_q <= '1;
    else blank_q <= blank_d;
  assign bus.blank_n = blank_q;
`else
  assign bus.blank_n = '1;
`endif
endmodule

// File: tb/tb_display_source_arbiter.sv
// tb_display_source_arbiter: directed grant/convert/dwell sequence with a result scoreboard.
module tb_display_source_arbiter;
  import display_pkg::*;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_ack = -1;
  logic [19:0] shown = '0;
  logic [24:0] sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  display_source_arbiter_if #(.N_REQ(N)) bus();
  display_source_arbiter #(.N_REQ(N), .DWELL_CYCLES(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] exp_blank(input int v);
    logic [4:0] b;
    int p;
    p = 1;
    b = '1;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    for (int i = 0; i < 5; i++) begin
      b[i] = (i == 0) || (v >= p);
      p = p * 10;
    end
`endif
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int v);
    bus.value[16*i+:16] = 16'(v);
    bus.req[i] = 1'b1;
  endtask

  task automatic wait_ack(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      tick();
      seen = |bus.ack;
    end
    chk("ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic grant(input int idx, input int v, input bit drop, input int space);
    bit seen;
    logic [24:0] e;
    wait_ack(seen);
    if (seen) begin
      chk("ack_onehot", 32'(bus.ack), 32'(1 << idx));
      chk("owner", 32'(bus.owner), 32'(idx));
      chk("busy_convert", 32'(bus.busy), 32'd1);
      if (space > 0 && last_ack >= 0) chk("spacing", 32'(cyc - last_ack), 32'(space));
      last_ack = cyc;
      sb.push_back({exp_blank(v), to_bcd(v)});
      if (drop) bus.req[idx] = 1'b0;
      tick();
      chk("ack_pulse", 32'(bus.ack), 32'd0);
      repeat (14) tick();
      chk("hold_old", 32'(bus.bcd_out), 32'(shown));
      tick();
      e = sb.pop_front();
      chk("bcd_out", 32'(bus.bcd_out), 32'(e[19:0]));
      chk("blank_n", 32'(bus.blank_n), 32'(e[24:20]));
      chk("bcd_valid", 32'(bus.bcd_valid), 32'd1);
      shown = e[19:0];
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ack"}, 32'(bus.ack), 32'd0);
    chk({tag, "_owner"}, 32'(bus.owner), 32'd0);
    chk({tag, "_bcd"}, 32'(bus.bcd_out), 32'd0);
    chk({tag, "_valid"}, 32'(bus.bcd_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_blank"}, 32'(bus.blank_n), 32'h1f);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1;
    bus.req = '0;
    bus.value = '0;
    tick();
    tick();
    reset_checks("reset");
    rst = 1'b0;
    // single requester, then range corners and blanking values
    set_req(0, 1234); grant(0, 1234, 1, 0);
    set_req(0, 65535); grant(0, 65535, 1, 0);
    set_req(0, 0); grant(0, 0, 1, 0);
    set_req(0, 10000); grant(0, 10000, 1, 0);
    set_req(0, 7); grant(0, 7, 1, 0);
    set_req(3, 42); grant(3, 42, 1, 0);
    // all four held: strict rotation at 1+16+D spacing
    set_req(0, 11); set_req(1, 222); set_req(2, 3333); set_req(3, 44444);
    grant(0, 11, 0, 0);
    grant(1, 222, 0, 1 + 16 + D);
    grant(2, 3333, 0, 1 + 16 + D);
    grant(3, 44444, 0, 1 + 16 + D);
    grant(0, 11, 0, 1 + 16 + D);
    bus.req = '0;
    // owner re-requests during dwell
    set_req(2, 111); grant(2, 111, 1, 0);
    set_req(2, 222);
    tick();
    chk("dwell_no_ack", 32'(bus.ack), 32'd0);
    chk("dwell_busy", 32'(bus.busy), 32'd1);
    grant(2, 222, 1, 1 + 16 + D);
    // reset mid-conversion, then pointer restarts at 0
    set_req(2, 999);
    wait_ack(seen);
    bus.req = '0;
    repeat (8) tick();
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    tick();
    rst = 1'b0;
    shown = '0;
    last_ack = -1;
    set_req(3, 321); set_req(0, 555);
    grant(0, 555, 1, 0);
    grant(3, 321, 1, 1 + 16 + D);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
